// File: rtl/rx_pkt_pkg.sv
// rtl/rx_pkt_pkg.sv - word type codes, dispatch state encoding and word-width helpers
package rx_pkt_pkg;

  localparam logic [2:0] TYPE_HDR  = 3'b101;
  localparam logic [2:0] TYPE_MID  = 3'b100;
  localparam logic [2:0] TYPE_TAIL = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XMIT    = 2'd1,
    TAILOUT = 2'd2,
    DISCARD = 2'd3
  } state_t;

  function automatic int mod_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int word_w(input int data_w);
    return data_w + 3 + mod_w(data_w);
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// rtl/sync_fifo_sa.sv - show-ahead synchronous FIFO with sync clear and usedw/empty/full
module sync_fifo_sa #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_wrreq,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rdreq,
  output logic [WIDTH-1:0] o_q,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW-1:0]    o_usedw
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr    = i_wrreq && !o_full && !i_clr;
  assign w_rd    = i_rdreq && !o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = r_count[AW];
  // usedw wraps to 0 at exactly full; o_full disambiguates
  assign o_usedw = r_count[AW-1:0];
  assign o_q     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    end
  end

endmodule

// File: rtl/rx_crc_strip_dispatch.sv
// rtl/rx_crc_strip_dispatch.sv - CRC strip, runt/bad drop and UM/loopback dispatch; RX_STRIP_STATS_EN adds packet counters
module rx_crc_strip_dispatch
  import rx_pkt_pkg::*;
#(
  parameter int  DATA_W      = 128,
  parameter int  MOD_W       = mod_w(DATA_W),
  parameter int  CRC_BYTES   = 4,
  parameter int  DFIFO_AW    = 8,
  parameter int  FFIFO_AW    = 6,
  parameter int  LOOP_THRESH = 161,
  localparam int W           = DATA_W + 3 + MOD_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                crc_check_wrreq,
  input  logic [W-1:0]        crc_check_data,
  output logic [DFIFO_AW-1:0] crc_usedw,
  input  logic                crc_result_wrreq,
  input  logic                crc_result,
  input  logic                um2cdp_tx_enable,
  input  logic                um2cdp_path,
  output logic                cdp2um_data_valid,
  output logic [W-1:0]        cdp2um_data,
  output logic                input2output_wrreq,
  output logic [W-1:0]        input2output_data,
  input  logic [7:0]          input2output_usedw
`ifdef RX_STRIP_STATS_EN
  ,
  output logic [31:0]         pkt_fwd_cnt,
  output logic [31:0]         pkt_crc_drop_cnt,
  output logic [31:0]         pkt_runt_cnt
`endif
);

  localparam logic [MOD_W:0] L_B   = (MOD_W+1)'(CRC_BYTES);
  localparam logic [MOD_W:0] L_NB  = (MOD_W+1)'(DATA_W / 8);
  localparam logic [8:0]     L_THR = 9'(LOOP_THRESH);

  state_t        r_state;
  logic [W-1:0]  r_prev;
  logic          r_prev_hdr;
  logic          r_dst;
  logic          r_um_valid;
  logic [W-1:0]  r_um_data;
  logic          r_lb_wrreq;
  logic [W-1:0]  r_lb_data;

  logic               w_clr;
  logic [W-1:0]       w_d_q;
  logic               w_d_empty;
  logic               w_d_full;
  logic               w_d_rd;
  logic               w_f_q;
  logic               w_f_empty;
  logic               w_f_full;
  logic [FFIFO_AW-1:0] w_f_usedw;
  logic               w_f_rd;

  logic               w_start;
  logic               w_xmit_pop;
  logic               w_is_tail;
  logic [MOD_W-1:0]   w_q_field;
  logic [MOD_W:0]     w_v;
  logic               w_v_gt_b;
  logic [MOD_W-1:0]   w_tail_field;
  logic [MOD_W:0]     w_short_sum;
  logic [MOD_W-1:0]   w_short_field;
  logic               w_emit;
  logic [W-1:0]       w_emit_data;
  logic               w_unused;

  assign w_clr = !reset;

  sync_fifo_sa #(.WIDTH(W), .AW(DFIFO_AW)) u_data_fifo (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_wrreq (crc_check_wrreq),
    .i_data  (crc_check_data),
    .i_rdreq (w_d_rd),
    .o_q     (w_d_q),
    .o_empty (w_d_empty),
    .o_full  (w_d_full),
    .o_usedw (crc_usedw)
  );

  sync_fifo_sa #(.WIDTH(1), .AW(FFIFO_AW)) u_flag_fifo (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_wrreq (crc_result_wrreq),
    .i_data  (crc_result),
    .i_rdreq (w_f_rd),
    .o_q     (w_f_q),
    .o_empty (w_f_empty),
    .o_full  (w_f_full),
    .o_usedw (w_f_usedw)
  );

  assign w_start = (r_state == IDLE) && !w_f_empty && um2cdp_tx_enable &&
                   (!um2cdp_path || ({1'b0, input2output_usedw} < L_THR));
  assign w_xmit_pop = (r_state == XMIT) && !w_d_empty;
  assign w_f_rd = w_start;
  assign w_d_rd = w_start || (((r_state == XMIT) || (r_state == DISCARD)) && !w_d_empty);

  assign w_is_tail     = (w_d_q[W-1:W-3] == TYPE_TAIL);
  assign w_q_field     = w_d_q[W-4:DATA_W];
  assign w_v           = {1'b0, w_q_field} + {{MOD_W{1'b0}}, 1'b1};
  assign w_v_gt_b      = (w_v > L_B);
  assign w_tail_field  = w_q_field - L_B[MOD_W-1:0];
  assign w_short_sum   = L_NB - L_B + {1'b0, w_q_field};
  assign w_short_field = (w_v == L_B) ? {MOD_W{1'b1}} : w_short_sum[MOD_W-1:0];

  // Decide what (if anything) leaves this cycle; prev is only released once its successor is seen
  always_comb begin
    w_emit      = 1'b0;
    w_emit_data = r_prev;
    if (r_state == TAILOUT) begin
      w_emit = 1'b1;
    end else if (w_xmit_pop) begin
      if (!w_is_tail || w_v_gt_b) begin
        w_emit = 1'b1;
      end else if (!r_prev_hdr) begin
        w_emit      = 1'b1;
        w_emit_data = {TYPE_TAIL, w_short_field, r_prev[DATA_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_prev     <= '0;
      r_prev_hdr <= 1'b0;
      r_dst      <= 1'b0;
      r_um_valid <= 1'b0;
      r_um_data  <= '0;
      r_lb_wrreq <= 1'b0;
      r_lb_data  <= '0;
    end else begin
      r_um_valid <= 1'b0;
      r_lb_wrreq <= 1'b0;
      if (w_emit) begin
        if (r_dst) begin
          r_lb_wrreq <= 1'b1;
          r_lb_data  <= w_emit_data;
        end else begin
          r_um_valid <= 1'b1;
          r_um_data  <= w_emit_data;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_dst      <= um2cdp_path;
            r_prev     <= w_d_q;
            r_prev_hdr <= 1'b1;
            if (w_is_tail)   r_state <= IDLE;
            else if (w_f_q)  r_state <= XMIT;
            else             r_state <= DISCARD;
          end
        end
        XMIT: begin
          if (!w_d_empty) begin
            r_prev_hdr <= 1'b0;
            if (!w_is_tail) begin
              r_prev <= w_d_q;
            end else if (w_v_gt_b) begin
              r_prev  <= {TYPE_TAIL, w_tail_field, w_d_q[DATA_W-1:0]};
              r_state <= TAILOUT;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        TAILOUT: r_state <= IDLE;
        DISCARD: begin
          if (!w_d_empty && w_is_tail) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cdp2um_data_valid  = r_um_valid;
  assign cdp2um_data        = r_um_data;
  assign input2output_wrreq = r_lb_wrreq;
  assign input2output_data  = r_lb_data;

  assign w_unused = ^{w_d_full, w_f_full, w_f_usedw, w_short_sum[MOD_W]};

`ifdef RX_STRIP_STATS_EN
  logic        w_cnt_fwd;
  logic        w_cnt_drop;
  logic        w_cnt_runt;
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_drop_cnt;
  logic [31:0] r_runt_cnt;

  assign w_cnt_fwd  = w_xmit_pop && w_is_tail && (w_v_gt_b || !r_prev_hdr);
  assign w_cnt_drop = w_start && !w_f_q;
  assign w_cnt_runt = (w_start && w_f_q && w_is_tail) ||
                      (w_xmit_pop && w_is_tail && !w_v_gt_b && r_prev_hdr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
      r_runt_cnt <= '0;
    end else begin
      if (w_cnt_fwd  && (r_fwd_cnt  != '1)) r_fwd_cnt  <= r_fwd_cnt  + 32'd1;
      if (w_cnt_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_cnt_runt && (r_runt_cnt != '1)) r_runt_cnt <= r_runt_cnt + 32'd1;
    end
  end

  assign pkt_fwd_cnt      = r_fwd_cnt;
  assign pkt_crc_drop_cnt = r_drop_cnt;
  assign pkt_runt_cnt     = r_runt_cnt;
`endif

endmodule

// File: tb/tb_rx_crc_strip_dispatch.sv
// tb/tb_rx_crc_strip_dispatch.sv - scoreboard bench for rx_crc_strip_dispatch
module tb_rx_crc_strip_dispatch;
  import rx_pkt_pkg::*;

  localparam int DATA_W = 128;
  localparam int MOD_W  = mod_w(DATA_W);
  localparam int W      = word_w(DATA_W);
  localparam int B      = 4;
  localparam int NB     = DATA_W / 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         crc_check_wrreq;
  logic [W-1:0] crc_check_data;
  logic [7:0]   crc_usedw;
  logic         crc_result_wrreq;
  logic         crc_result;
  logic         um2cdp_tx_enable;
  logic         um2cdp_path;
  logic         cdp2um_data_valid;
  logic [W-1:0] cdp2um_data;
  logic         input2output_wrreq;
  logic [W-1:0] input2output_data;
  logic [7:0]   input2output_usedw;
`ifdef RX_STRIP_STATS_EN
  logic [31:0]  pkt_fwd_cnt;
  logic [31:0]  pkt_crc_drop_cnt;
  logic [31:0]  pkt_runt_cnt;
`endif

  always #5 clk = ~clk;

  rx_crc_strip_dispatch dut (
    .clk                (clk),
    .reset              (reset),
    .crc_check_wrreq    (crc_check_wrreq),
    .crc_check_data     (crc_check_data),
    .crc_usedw          (crc_usedw),
    .crc_result_wrreq   (crc_result_wrreq),
    .crc_result         (crc_result),
    .um2cdp_tx_enable   (um2cdp_tx_enable),
    .um2cdp_path        (um2cdp_path),
    .cdp2um_data_valid  (cdp2um_data_valid),
    .cdp2um_data        (cdp2um_data),
    .input2output_wrreq (input2output_wrreq),
    .input2output_data  (input2output_data),
    .input2output_usedw (input2output_usedw)
`ifdef RX_STRIP_STATS_EN
    ,
    .pkt_fwd_cnt        (pkt_fwd_cnt),
    .pkt_crc_drop_cnt   (pkt_crc_drop_cnt),
    .pkt_runt_cnt       (pkt_runt_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  int exp_runt = 0;
  logic [W-1:0] exp_um [$];
  logic [W-1:0] exp_lb [$];
  logic [W-1:0] hold_um;
  logic [W-1:0] hold_lb;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: what a packet should turn into, derived from the strip rules directly
  task automatic model(input logic [W-1:0] w [$], input bit good, input bit path);
    logic [W-1:0] o [$];
    int n, tf, v, nf;
    n  = w.size();
    tf = int'(w[n-1][W-4:DATA_W]);
    v  = tf + 1;
    if (!good) begin
      exp_drop++;
      return;
    end
    if (n == 2 && v <= B) begin
      exp_runt++;
      return;
    end
    exp_fwd++;
    if (v > B) begin
      for (int i = 0; i < n - 1; i++) o.push_back(w[i]);
      o.push_back({TYPE_TAIL, MOD_W'(tf - B), w[n-1][DATA_W-1:0]});
    end else begin
      for (int i = 0; i < n - 2; i++) o.push_back(w[i]);
      nf = (v == B) ? NB - 1 : NB - B + tf;
      o.push_back({TYPE_TAIL, MOD_W'(nf), w[n-2][DATA_W-1:0]});
    end
    foreach (o[i]) begin
      if (path) exp_lb.push_back(o[i]);
      else      exp_um.push_back(o[i]);
    end
  endtask

  task automatic send_pkt(input int n, input bit good, input bit path, input int tail_field);
    logic [W-1:0] w [$];
    logic [2:0] t;
    logic [MOD_W-1:0] f;
    logic [DATA_W-1:0] p;
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? TYPE_HDR : ((i == n - 1) ? TYPE_TAIL : TYPE_MID);
      f = (i == n - 1) ? MOD_W'(tail_field) : MOD_W'(NB - 1);
      p = {$urandom, $urandom, $urandom, $urandom};
      w.push_back({t, f, p});
    end
    model(w, good, path);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      crc_check_wrreq = 1'b1;
      crc_check_data  = w[i];
    end
    @(posedge clk); #1;
    crc_check_wrreq  = 1'b0;
    crc_result_wrreq = 1'b1;
    crc_result       = good;
    @(posedge clk); #1;
    crc_result_wrreq = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      hold_um = '0;
      hold_lb = '0;
    end else begin
      if (cdp2um_data_valid) begin
        if (exp_um.size() == 0) begin
          checks++; errors++;
          $display("FAIL um_unexpected got=%h exp=none", cdp2um_data);
        end else chk("um_word", cdp2um_data, exp_um.pop_front());
        hold_um = cdp2um_data;
      end else chk("um_hold", cdp2um_data, hold_um);
      if (input2output_wrreq) begin
        if (exp_lb.size() == 0) begin
          checks++; errors++;
          $display("FAIL lb_unexpected got=%h exp=none", input2output_data);
        end else chk("lb_word", input2output_data, exp_lb.pop_front());
        hold_lb = input2output_data;
      end else chk("lb_hold", input2output_data, hold_lb);
    end
  end

  initial begin
    int k, tot, n;
    bit path;
    reset = 1'b0;
    crc_check_wrreq = 1'b0;
    crc_check_data = '0;
    crc_result_wrreq = 1'b0;
    crc_result = 1'b0;
    um2cdp_tx_enable = 1'b1;
    um2cdp_path = 1'b0;
    input2output_usedw = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_um_valid", W'(cdp2um_data_valid), '0);
    chk("rst_lb_wrreq", W'(input2output_wrreq), '0);
    chk("rst_um_data", cdp2um_data, '0);
    chk("rst_lb_data", input2output_data, '0);
    chk("rst_usedw", W'(crc_usedw), '0);
    @(posedge clk); #1;
    reset = 1'b1;

    send_pkt(5, 1'b1, 1'b0, 9);
    idle(12);
    um2cdp_path = 1'b1; input2output_usedw = 8'd100;
    send_pkt(5, 1'b1, 1'b1, 3);
    idle(12);
    um2cdp_path = 1'b0;
    send_pkt(5, 1'b1, 1'b0, 1);
    idle(12);
    send_pkt(6, 1'b0, 1'b0, 7);
    send_pkt(4, 1'b1, 1'b0, 12);
    idle(20);

    um2cdp_path = 1'b1; input2output_usedw = 8'd161;
    send_pkt(2, 1'b1, 1'b1, 2);
    idle(10);
    chk("gate_thresh_hold", W'(crc_usedw), W'(2));
    input2output_usedw = 8'd160;
    idle(10);
    chk("gate_thresh_go", W'(crc_usedw), '0);
`ifdef RX_STRIP_STATS_EN
    chk("runt_cnt", W'(pkt_runt_cnt), W'(1));
`endif

    um2cdp_path = 1'b0; um2cdp_tx_enable = 1'b0;
    send_pkt(3, 1'b1, 1'b0, 15);
    idle(8);
    chk("txen_hold", W'(crc_usedw), W'(3));
    um2cdp_tx_enable = 1'b1;
    idle(10);

    send_pkt(8, 1'b1, 1'b0, 15);
    idle(3);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_um_valid", W'(cdp2um_data_valid), '0);
    chk("rst_mid_lb_wrreq", W'(input2output_wrreq), '0);
    chk("rst_mid_usedw", W'(crc_usedw), '0);
    exp_um.delete();
    exp_lb.delete();
    exp_fwd = 0; exp_drop = 0; exp_runt = 0;
    @(posedge clk); #1;
    send_pkt(4, 1'b1, 1'b0, 6);
    idle(12);

    for (int g = 0; g < 40; g++) begin
      path = 1'($urandom_range(1));
      um2cdp_path = path;
      input2output_usedw = 8'($urandom_range(160));
      k = $urandom_range(3, 1);
      tot = 0;
      for (int j = 0; j < k; j++) begin
        n = $urandom_range(8, 2);
        tot += n;
        send_pkt(n, ($urandom_range(3) != 0), path, $urandom_range(15));
      end
      idle(tot + 4 * k + 10);
    end

    idle(10);
    chk("um_queue_drained", W'(exp_um.size()), '0);
    chk("lb_queue_drained", W'(exp_lb.size()), '0);
`ifdef RX_STRIP_STATS_EN
    chk("fwd_cnt", W'(pkt_fwd_cnt), W'(exp_fwd));
    chk("drop_cnt", W'(pkt_crc_drop_cnt), W'(exp_drop));
    chk("runt_cnt_end", W'(pkt_runt_cnt), W'(exp_runt));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
